// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-tile successor generator: move directions,
// FSM states and the state-word layout helpers for an N x N board.
package puzzle_pkg;

  // Direction of the blank's motion; the reverse of d is d ^ 1.
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StExpand
  } state_e;

  function automatic int unsigned calc_tile_w(int unsigned n);
    return $clog2(n * n);
  endfunction

  function automatic int unsigned calc_tiles_w(int unsigned n);
    return n * n * calc_tile_w(n);
  endfunction

  function automatic int unsigned calc_state_w(int unsigned n, int unsigned depth_w);
    return calc_tile_w(n) + depth_w + 3 + calc_tiles_w(n);
  endfunction

  // Field offsets, MSB to LSB: {pos, depth, last_valid, last_dir[2], tiles}.
  function automatic int unsigned off_last_dir(int unsigned n);
    return calc_tiles_w(n);
  endfunction

  function automatic int unsigned off_last_valid(int unsigned n);
    return calc_tiles_w(n) + 2;
  endfunction

  function automatic int unsigned off_depth(int unsigned n);
    return calc_tiles_w(n) + 3;
  endfunction

  function automatic int unsigned off_pos(int unsigned n, int unsigned depth_w);
    return calc_tiles_w(n) + 3 + depth_w;
  endfunction

  function automatic int unsigned pos_row(int unsigned pos, int unsigned n);
    return pos / n;
  endfunction

  function automatic int unsigned pos_col(int unsigned pos, int unsigned n);
    return pos % n;
  endfunction

endpackage

// File: rtl/puzzle_expander_blank_mover.sv
// Combinational single-move engine: slides the blank one cell in the given
// direction, swapping the target tile into the old blank position.
module blank_mover
  import puzzle_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned TILE_W = calc_tile_w(N),
  localparam int unsigned TILES_W = calc_tiles_w(N)
) (
  input  logic [TILES_W-1:0] tiles_i,
  input  logic [TILE_W-1:0]  pos_i,
  input  logic [1:0]         dir_i,
  output logic [TILES_W-1:0] tiles_o,
  output logic [TILE_W-1:0]  pos_o,
  output logic               onboard_o
);

  localparam int unsigned Cells = N * N;

  // Resolve the target cell, then swap it with the blank when it is on the board.
  always_comb begin
    int unsigned p;
    int unsigned row;
    int unsigned col;
    int unsigned tgt;
    p         = 32'(pos_i);
    row       = pos_row(p, N);
    col       = pos_col(p, N);
    tgt       = p;
    onboard_o = 1'b0;
    tiles_o   = tiles_i;
    pos_o     = pos_i;
    if (p < Cells) begin
      unique case (dir_i)
        UP:    if (row > 0)     begin onboard_o = 1'b1; tgt = p - N; end
        DOWN:  if (row < N - 1) begin onboard_o = 1'b1; tgt = p + N; end
        LEFT:  if (col > 0)     begin onboard_o = 1'b1; tgt = p - 1; end
        RIGHT: if (col < N - 1) begin onboard_o = 1'b1; tgt = p + 1; end
      endcase
    end
    if (onboard_o) begin
      tiles_o[p*TILE_W +: TILE_W]   = tiles_i[tgt*TILE_W +: TILE_W];
      tiles_o[tgt*TILE_W +: TILE_W] = '0;
      pos_o                         = TILE_W'(tgt);
    end
  end

endmodule

// File: rtl/puzzle_expander.sv
// Successor-state generator: takes one parent board and streams each legal
// child, in ascending direction order, through a one-entry output register.
module puzzle_expander
  import puzzle_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned DEPTH_W = 4,
  localparam int unsigned TILE_W = calc_tile_w(N),
  localparam int unsigned TILES_W = calc_tiles_w(N),
  localparam int unsigned STATE_W = calc_state_w(N, DEPTH_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] in_state_i,
  input  logic [DEPTH_W-1:0] depth_limit_i,
  input  logic [TILES_W-1:0] goal_tiles_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] out_state_o,
  output logic               out_goal_o,
  output logic               out_last_o,
  output logic               empty_pulse_o,
  output logic               err_pulse_o,
  output logic [15:0]        child_cnt_o
);

  localparam int unsigned Cells    = N * N;
  localparam int unsigned OffLd    = off_last_dir(N);
  localparam int unsigned OffLv    = off_last_valid(N);
  localparam int unsigned OffDepth = off_depth(N);
  localparam int unsigned OffPos   = off_pos(N, DEPTH_W);

  function automatic logic [3:0] legal_mask(logic [TILE_W-1:0] pos, logic [DEPTH_W-1:0] depth,
                                            logic lv, logic [1:0] ld, logic [DEPTH_W-1:0] limit);
    logic [3:0]  m;
    int unsigned row;
    int unsigned col;
    row      = pos_row(32'(pos), N);
    col      = pos_col(32'(pos), N);
    m[UP]    = row > 0;
    m[DOWN]  = row < N - 1;
    m[LEFT]  = col > 0;
    m[RIGHT] = col < N - 1;
    if (lv) m[ld ^ 2'b01] = 1'b0;
    if (depth >= limit) m = '0;
    return m;
  endfunction

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   parent_q, parent_d;
  logic [2:0]           dir_cnt_q, dir_cnt_d;
  logic [STATE_W-1:0]   out_state_q, out_state_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_goal_q, out_goal_d;
  logic                 out_last_q, out_last_d;
  logic                 empty_q, empty_d;
  logic                 err_q, err_d;
  logic [15:0]          child_cnt_q;

  logic [TILE_W-1:0]    in_pos, p_pos, mv_pos;
  logic [DEPTH_W-1:0]   p_depth;
  logic [TILES_W-1:0]   p_tiles, mv_tiles;
  logic [3:0]           mask_in, mask_p;
  logic [1:0]           sel_dir;
  logic                 found, is_last, mv_onboard, load_free;

  assign in_pos  = in_state_i[OffPos +: TILE_W];
  assign p_pos   = parent_q[OffPos +: TILE_W];
  assign p_depth = parent_q[OffDepth +: DEPTH_W];
  assign p_tiles = parent_q[TILES_W-1:0];
  assign mask_in = legal_mask(in_pos, in_state_i[OffDepth +: DEPTH_W], in_state_i[OffLv],
                              in_state_i[OffLd +: 2], depth_limit_i);
  assign mask_p  = legal_mask(p_pos, p_depth, parent_q[OffLv], parent_q[OffLd +: 2],
                              depth_limit_i);

  // Priority search: lowest legal direction not yet emitted, and whether any follows it.
  always_comb begin
    found   = 1'b0;
    sel_dir = '0;
    is_last = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      if (mask_p[d] && 3'(d) >= dir_cnt_q) begin
        found   = 1'b1;
        sel_dir = 2'(d);
      end
    end
    for (int d = 0; d < 4; d++) begin
      if (mask_p[d] && 2'(d) > sel_dir) is_last = 1'b0;
    end
  end

  blank_mover #(
    .N(N)
  ) u_mover (
    .tiles_i  (p_tiles),
    .pos_i    (p_pos),
    .dir_i    (sel_dir),
    .tiles_o  (mv_tiles),
    .pos_o    (mv_pos),
    .onboard_o(mv_onboard)
  );

  assign load_free = !out_valid_q || out_ready_i;

  // Next-state: parent capture in idle, one child load per free output slot in expand.
  always_comb begin
    state_d     = state_q;
    parent_d    = parent_q;
    dir_cnt_d   = dir_cnt_q;
    out_state_d = out_state_q;
    out_goal_d  = out_goal_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready_i;
    empty_d     = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          parent_d  = in_state_i;
          dir_cnt_d = '0;
          if (32'(in_pos) >= Cells) err_d = 1'b1;
          else if (mask_in == 4'b0000) empty_d = 1'b1;
          else state_d = StExpand;
        end
      end
      StExpand: begin
        if (found && mv_onboard && load_free) begin
          out_valid_d = 1'b1;
          out_state_d = {mv_pos, p_depth + DEPTH_W'(1), 1'b1, sel_dir, mv_tiles};
          out_goal_d  = (mv_tiles == goal_tiles_i);
          out_last_d  = is_last;
          dir_cnt_d   = 3'(sel_dir) + 3'd1;
          if (is_last) state_d = StIdle;
        end
      end
    endcase
  end

  // State registers with synchronous reset; the accepted-child counter saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      parent_q    <= '0;
      dir_cnt_q   <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      out_goal_q  <= 1'b0;
      out_last_q  <= 1'b0;
      empty_q     <= 1'b0;
      err_q       <= 1'b0;
      child_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      parent_q    <= parent_d;
      dir_cnt_q   <= dir_cnt_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      out_goal_q  <= out_goal_d;
      out_last_q  <= out_last_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
      if (out_valid_q && out_ready_i && child_cnt_q != 16'hFFFF) begin
        child_cnt_q <= child_cnt_q + 16'd1;
      end
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = out_valid_q;
  assign out_state_o   = out_state_q;
  assign out_goal_o    = out_goal_q;
  assign out_last_o    = out_last_q;
  assign empty_pulse_o = empty_q;
  assign err_pulse_o   = err_q;
  assign child_cnt_o   = child_cnt_q;

endmodule
